// File: rtl/rob_commit_ctrl_pkg.sv
// Shared definitions for the ROB commit controller: FSM encodings, reserved tag,
// default widths and the mispredict test.
package rob_commit_ctrl_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_Q_WIDTH        = 4;
  localparam int TAG_RESERVED       = 0;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_STORE_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;

  function automatic logic is_mispredict(input logic [31:0] npc, input logic [31:0] pred);
    return npc != pred;
  endfunction

endpackage

// File: rtl/commit_perf_cnt.sv
// Retired-instruction and mispredict counters; both wrap modulo 2^32.
module commit_perf_cnt (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        inc_commit,
  input  logic        inc_mispred,
  output logic [31:0] commit_cnt,
  output logic [31:0] mispred_cnt
);

  logic [31:0] commit_cnt_q, commit_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    commit_cnt_d  = commit_cnt_q + {31'd0, inc_commit};
    mispred_cnt_d = mispred_cnt_q + {31'd0, inc_mispred};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      commit_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      commit_cnt_q  <= commit_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign commit_cnt  = commit_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB retirement: regfile writeback, store release handshake, mispredict flush.
// Define COMMIT_PERF_CNT_EN to build the commit/mispredict counters; otherwise they read 0.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int Q_WIDTH        = DEF_Q_WIDTH,
  parameter int FLUSH_CYCLES   = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      head_valid,
  input  logic                      head_is_store,
  input  logic                      head_is_branch,
  input  logic [REG_ADDR_WIDTH-1:0] head_reg_addr,
  input  logic [Q_WIDTH-1:0]        head_q,
  input  logic [31:0]               head_v,
  input  logic [31:0]               head_npc,
  input  logic [31:0]               head_pred_pc,
  output logic                      commit_pop,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [31:0]               rf_data,
  output logic [Q_WIDTH-1:0]        rf_q,
  output logic                      store_req,
  output logic [Q_WIDTH-1:0]        store_q,
  input  logic                      store_done,
  output logic                      flush_out,
  output logic [31:0]               redirect_pc,
  output logic [31:0]               commit_cnt,
  output logic [31:0]               mispred_cnt
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [1:0]         state_q, state_d;
  logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [Q_WIDTH-1:0] st_tag_q, st_tag_d;
  logic               active;

  // Nothing retires in a reset cycle; the entry is retried once reset lifts.
  assign active = rdy_in & rst_in;

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_pc_d = redirect_pc_q;
    st_tag_d      = st_tag_q;
    commit_pop    = 1'b0;
    rf_we         = 1'b0;
    rf_addr       = '0;
    rf_data       = 32'd0;
    rf_q          = Q_WIDTH'(TAG_RESERVED);
    store_req     = 1'b0;
    store_q       = Q_WIDTH'(TAG_RESERVED);
    case (state_q)
      ST_IDLE: begin
        if (active && head_valid) begin
          if (head_is_store) begin
            store_req = 1'b1;
            store_q   = head_q;
            st_tag_d  = head_q;
            state_d   = ST_STORE_WAIT;
          end else if (head_is_branch) begin
            commit_pop = 1'b1;
            if (is_mispredict(head_npc, head_pred_pc)) begin
              redirect_pc_d = head_npc;
              flush_cnt_d   = FCW'(FLUSH_CYCLES - 1);
              state_d       = ST_FLUSH;
            end
          end else begin
            commit_pop = 1'b1;
            rf_we      = (head_reg_addr != '0);
            rf_addr    = head_reg_addr;
            rf_data    = head_v;
            rf_q       = head_q;
          end
        end
      end
      ST_STORE_WAIT: begin
        // Tag is latched so it stays stable even if the head inputs wander.
        store_q = st_tag_q;
        if (active) begin
          store_req = 1'b1;
          if (store_done) begin
            commit_pop = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (active) begin
          if (flush_cnt_q == '0) state_d = ST_IDLE;
          else                   flush_cnt_d = flush_cnt_q - FCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= '0;
      redirect_pc_q <= 32'd0;
      st_tag_q      <= '0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      st_tag_q      <= st_tag_d;
    end
  end

  assign flush_out   = (state_q == ST_FLUSH);
  assign redirect_pc = redirect_pc_q;

`ifdef COMMIT_PERF_CNT_EN
  logic flush_entry;
  assign flush_entry = (state_q != ST_FLUSH) && (state_d == ST_FLUSH);

  commit_perf_cnt u_perf (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .inc_commit  (commit_pop),
    .inc_mispred (flush_entry),
    .commit_cnt  (commit_cnt),
    .mispred_cnt (mispred_cnt)
  );
`else
  assign commit_cnt  = 32'h0;
  assign mispred_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Scoreboard bench for rob_commit_ctrl: directed spec scenarios, then random traffic
// checked against an instruction-level retirement model.
module tb_rob_commit_ctrl;
  localparam int RAW = 5;
  localparam int QW  = 4;
  localparam int FC  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in = 1'b0, rdy_in = 1'b1;
  logic head_valid = 1'b0, head_is_store = 1'b0, head_is_branch = 1'b0;
  logic [RAW-1:0] head_reg_addr = '0;
  logic [QW-1:0]  head_q = '0;
  logic [31:0]    head_v = '0, head_npc = '0, head_pred_pc = '0;
  logic store_done = 1'b0;
  logic commit_pop, rf_we, store_req, flush_out;
  logic [RAW-1:0] rf_addr;
  logic [31:0]    rf_data, redirect_pc, commit_cnt, mispred_cnt;
  logic [QW-1:0]  rf_q, store_q;

  rob_commit_ctrl #(.REG_ADDR_WIDTH(RAW), .Q_WIDTH(QW), .FLUSH_CYCLES(FC)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .head_valid(head_valid), .head_is_store(head_is_store), .head_is_branch(head_is_branch),
    .head_reg_addr(head_reg_addr), .head_q(head_q), .head_v(head_v),
    .head_npc(head_npc), .head_pred_pc(head_pred_pc),
    .commit_pop(commit_pop), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_q(rf_q),
    .store_req(store_req), .store_q(store_q), .store_done(store_done),
    .flush_out(flush_out), .redirect_pc(redirect_pc),
    .commit_cnt(commit_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic           is_store;
    logic           is_branch;
    logic [RAW-1:0] rd;
    logic [QW-1:0]  q;
    logic [31:0]    v;
    logic [31:0]    npc;
    logic [31:0]    pred;
  } instr_t;

  instr_t prog[$];   // what the ROB head will present, in order
  instr_t exp_q[$];  // expected retirements, in order
  int hd = 0;
  int checks = 0, failures = 0;
  int req_cnt = 0, pop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic instr_t mk(input logic st, input logic br, input logic [RAW-1:0] rd,
                                input logic [QW-1:0] q, input logic [31:0] v,
                                input logic [31:0] npc, input logic [31:0] pred);
    instr_t r;
    r.is_store = st; r.is_branch = br; r.rd = rd; r.q = q; r.v = v; r.npc = npc; r.pred = pred;
    return r;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t r;
    int k = $urandom_range(0, 99);
    r.is_store  = (k < 25);
    r.is_branch = (k >= 25) && (k < 60);
    r.rd   = ($urandom_range(0, 4) == 0) ? '0 : RAW'($urandom_range(1, 31));
    r.q    = QW'($urandom_range(1, 15));
    r.v    = $urandom;
    r.npc  = $urandom & 32'hFFFF_FFFC;
    r.pred = ($urandom_range(0, 1) == 1) ? r.npc : r.npc + 32'd4;
    return r;
  endfunction

  task automatic issue(input instr_t i);
    prog.push_back(i);
    exp_q.push_back(i);
  endtask

  // One clock of stimulus; head follows the program, advancing when a pop is seen.
  task automatic cyc(input logic hv, input logic rdy, input logic sd, input logic rst);
    logic popped;
    if (hd < prog.size()) begin
      head_is_store = prog[hd].is_store; head_is_branch = prog[hd].is_branch;
      head_reg_addr = prog[hd].rd;       head_q = prog[hd].q; head_v = prog[hd].v;
      head_npc      = prog[hd].npc;      head_pred_pc = prog[hd].pred;
      head_valid    = hv;
    end else begin
      head_valid = 1'b0;
    end
    rdy_in = rdy; store_done = sd; rst_in = rst;
    @(negedge clk);
    popped = commit_pop && rst_in;
    if (store_req) req_cnt++;
    if (popped) pop_cnt++;
    @(posedge clk);
    #1;
    if (popped) hd++;
  endtask

  // Monitor: abstract retirement model plus in-order scoreboard.
  int          flush_left = 0;
  logic [31:0] m_redir = '0, m_cnt = '0, m_mis = '0;
  logic        sw_pend = 1'b0;
  logic [QW-1:0] sw_tag = '0;

  initial begin
    instr_t e;
    forever begin
      @(negedge clk);
      chk("flush_out", flush_out, flush_left > 0);
      chk("redirect_pc", redirect_pc, m_redir);
`ifdef COMMIT_PERF_CNT_EN
      chk("commit_cnt", commit_cnt, m_cnt);
      chk("mispred_cnt", mispred_cnt, m_mis);
`else
      chk("commit_cnt_tied", commit_cnt, 0);
      chk("mispred_cnt_tied", mispred_cnt, 0);
`endif
      if (!rst_in) begin
        chk("reset_quiet", {commit_pop, rf_we, store_req}, 0);
        flush_left = 0; m_redir = '0; sw_pend = 1'b0; m_cnt = '0; m_mis = '0;
      end else begin
        if (!rdy_in) begin
          chk("frozen_quiet", {commit_pop, rf_we, store_req}, 0);
        end else if (flush_left > 0) begin
          chk("flush_quiet", {commit_pop, rf_we, store_req}, 0);
          flush_left--;
        end else if (sw_pend) begin
          chk("store_req_wait", store_req, 1);
          chk("store_q_wait", store_q, sw_tag);
          chk("store_pop", commit_pop, store_done);
          if (store_done) sw_pend = 1'b0;
        end else if (head_valid && head_is_store) begin
          chk("store_release", {store_req, commit_pop}, 2'b10);
          chk("store_q_release", store_q, head_q);
          sw_pend = 1'b1; sw_tag = head_q;
        end else if (head_valid) begin
          chk("same_cycle_pop", {commit_pop, store_req}, 2'b10);
        end else begin
          chk("idle_quiet", {commit_pop, rf_we, store_req}, 0);
        end
        if (commit_pop) begin
          if (exp_q.size() == 0) begin
            chk("pop_with_empty_scoreboard", 1, 0);
          end else begin
            e = exp_q.pop_front();
            m_cnt++;
            chk("rf_we", rf_we, !e.is_store && !e.is_branch && (e.rd != 0));
            if (!e.is_store && !e.is_branch) begin
              chk("rf_addr", rf_addr, e.rd);
              chk("rf_data", rf_data, e.v);
              chk("rf_q", rf_q, e.q);
            end
            if (e.is_store) chk("store_tag_at_pop", store_q, e.q);
            if (e.is_branch && (e.npc != e.pred)) begin
              flush_left = FC; m_redir = e.npc; m_mis++;
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    int p0;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    // ALU commit and x0 commit
    issue(mk(0, 0, 5'd5, 4'd3, 32'h1234, 0, 0));
    issue(mk(0, 0, 5'd0, 4'd4, 32'hDEAD, 0, 0));
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    chk("alu_pops", hd, 2);

    // Store q=7, done three cycles later (head_valid drops once while waiting)
    issue(mk(1, 0, 5'd0, 4'd7, 0, 0, 0));
    req_cnt = 0; pop_cnt = 0;
    cyc(1, 1, 1, 1);
    cyc(0, 1, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 1, 1);
    chk("store_req_cycles", req_cnt, 4);
    chk("store_pop_count", pop_cnt, 1);

    // Mispredict then an ALU op that must wait out the flush
    issue(mk(0, 1, 5'd0, 4'd5, 0, 32'h100, 32'h104));
    issue(mk(0, 0, 5'd2, 4'd6, 32'h55, 0, 0));
    pop_cnt = 0;
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    chk("pops_during_flush", pop_cnt, 1);
    cyc(1, 1, 0, 1);
    chk("pop_after_flush", pop_cnt, 2);

    // Correct branch
    issue(mk(0, 1, 5'd0, 4'd8, 0, 32'h200, 32'h200));
    cyc(1, 1, 0, 1);
    cyc(0, 1, 0, 1);

    // rdy_in low while waiting on a store
    issue(mk(1, 0, 5'd0, 4'd9, 0, 0, 0));
    cyc(1, 1, 0, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 1, 1);

    // Reset during FLUSH
    issue(mk(0, 1, 5'd0, 4'd10, 0, 32'h300, 32'h304));
    issue(mk(0, 0, 5'd7, 4'd11, 32'h77, 0, 0));
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(1, 1, 0, 1);

    // Reset during STORE_WAIT; the store is re-released afterwards
    issue(mk(1, 0, 5'd0, 4'd12, 0, 0, 0));
    cyc(1, 1, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 1);
    cyc(1, 1, 1, 1);
    cyc(1, 1, 1, 1);
    chk("directed_retired", hd, prog.size());

    // Random traffic
    for (int i = 0; i < 300; i++) issue(rnd_instr());
    n = 0;
    while (hd < prog.size() && n < 20000) begin
      cyc($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 90,
          $urandom_range(0, 99) < 35, $urandom_range(0, 99) >= 1);
      n++;
    end
    p0 = prog.size();
    chk("random_all_retired", hd, p0);
    chk("scoreboard_empty", exp_q.size(), 0);
    cyc(0, 1, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
